// File: rtl/r16_inv_scale_pkg.sv
// r16_inv_scale shared package.
// State encoding, default widths and the Goldilocks test modulus.
package r16_pkg;

    localparam int DEF_P_WIDTH = 64;
    localparam int DEF_CNT_W   = 6;

    localparam logic [63:0] P_GOLD = 64'hFFFF_FFFF_0000_0001;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/r16_inv_scale_if.sv
// r16_inv_scale handshake bundle.
// Upstream word, downstream result and both valid/ready pairs.
interface r16_inv_scale_if #(
    parameter int P_WIDTH = r16_pkg::DEF_P_WIDTH,
    parameter int CNT_W   = r16_pkg::DEF_CNT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [P_WIDTH-1:0] data_in;
    logic [P_WIDTH-1:0] A0_in;
    logic               Ac_in;
    logic [P_WIDTH:0]   Ninv2_in;
    logic [CNT_W-1:0]   k_in;
    logic               out_valid;
    logic               out_ready;
    logic [P_WIDTH-1:0] data_out;
    logic [P_WIDTH-1:0] A0_out;
    logic               Ac_out;

    modport slave (
        input  in_valid, data_in, A0_in, Ac_in,
        input  Ninv2_in, k_in, out_ready,
        output in_ready, out_valid,
        output data_out, A0_out, Ac_out
    );

    modport master (
        output in_valid, data_in, A0_in, Ac_in,
        output Ninv2_in, k_in, out_ready,
        input  in_ready, out_valid,
        input  data_out, A0_out, Ac_out
    );
endinterface

// File: rtl/r16_inv_scale_mod_half.sv
// r16_mod_half: one modular halving step.
// y = x/2 mod p for odd p, using a carry-safe wide sum.
module r16_mod_half #(
    parameter int P_WIDTH = r16_pkg::DEF_P_WIDTH
) (
    input  logic [P_WIDTH-1:0] x_i,
    input  logic [P_WIDTH-1:0] p_i,
    output logic [P_WIDTH-1:0] y_o
);
    logic [P_WIDTH:0] addend;
    logic [P_WIDTH:0] sum;

    // Odd x gets p added so the sum is even; the extra bit holds the carry.
    always_comb begin
        addend = x_i[0] ? {1'b0, p_i} : '0;
        sum    = {1'b0, x_i} + addend;
        y_o    = P_WIDTH'(sum >> 1);
    end
endmodule

// File: rtl/r16_inv_scale.sv
// r16_inv_scale: multiply a residue by 2^-k mod p.
// One halving per cycle; address/bank bits ride along untouched.
module r16_inv_scale
    import r16_pkg::*;
#(
    parameter int P_WIDTH = DEF_P_WIDTH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    r16_inv_scale_if.slave bus
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0] x_q, x_d;
    logic [P_WIDTH-1:0] p_q, p_d;
    logic [P_WIDTH-1:0] a0_q, a0_d;
    logic               ac_q, ac_d;
    logic [CNT_W-1:0]   k_eff;
    logic [P_WIDTH-1:0] x_half;

    r16_mod_half #(.P_WIDTH(P_WIDTH)) u_half (
        .x_i (x_q),
        .p_i (p_q),
        .y_o (x_half)
    );

    // Count is forced to zero when inverse mode is off.
    assign k_eff = bus.Ninv2_in[P_WIDTH] ? bus.k_in : '0;

    // Next-state, counter and capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        p_d     = p_q;
        a0_d    = a0_q;
        ac_d    = ac_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.data_in;
                    p_d     = bus.Ninv2_in[P_WIDTH-1:0];
                    a0_d    = bus.A0_in;
                    ac_d    = bus.Ac_in;
                    cnt_d   = k_eff;
                    state_d = (k_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                x_d   = x_half;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            p_q     <= '0;
            a0_q    <= '0;
            ac_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            p_q     <= p_d;
            a0_q    <= a0_d;
            ac_q    <= ac_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.data_out  = x_q;
    assign bus.A0_out    = a0_q;
    assign bus.Ac_out    = ac_q;
endmodule
